// File: rtl/tcspc_pkg.sv
// Shared encodings and helpers for the TCSPC histogram memory.
// Commands, FSM states and the per-bin increment policy.
package tcspc_pkg;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_CLEAR = 2'b01;
    localparam logic [1:0] CMD_START = 2'b10;
    localparam logic [1:0] CMD_DUMP  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_ACQ,
        ST_DRAIN,
        ST_DUMP
    } state_e;

    typedef enum logic [1:0] {
        INC_ADD,
        INC_HOLD,
        INC_WRAP
    } inc_op_e;

    // What a full-scale bin does on its next hit.
    function automatic inc_op_e inc_op(input logic all_ones, input logic sat);
        inc_op = !all_ones ? INC_ADD : (sat ? INC_HOLD : INC_WRAP);
    endfunction

endpackage

// File: rtl/tcspc_hist_ram.sv
// Histogram bin store: one write port, one registered read port.
// No reset; contents are zeroed by the clear sweep.
module tcspc_hist_ram #(
    parameter int DEPTH = 128,
    parameter int AW    = 7,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/tcspc_histogram_mem.sv
// Photon-arrival histogram: pipelined saturating bin increment,
// hardware clear sweep and valid/ready dump of every bin.
module tcspc_histogram_mem
    import tcspc_pkg::*;
#(
    parameter int NUM_BINS = 128,
    parameter int ADDR_W   = 7,
    parameter int COUNT_W  = 32,
    parameter int SATURATE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hit_valid,
    input  logic [ADDR_W-1:0]  hit_bin,
    input  logic [1:0]         cmd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_bin,
    output logic [COUNT_W-1:0] out_data,
    output logic               out_last,
    output logic               busy,
    output logic               acq_on,
    output logic               hit_drop,
    output logic               ovf
);

    localparam logic [ADDR_W:0]   NB    = (ADDR_W+1)'(NUM_BINS);
    localparam logic [ADDR_W:0]   NB_M1 = (ADDR_W+1)'(NUM_BINS-1);
    localparam logic [ADDR_W:0]   ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_BINS-1);

    state_e             state_q, state_d;
    logic [ADDR_W:0]    ptr_q, ptr_d;
    logic               drain_clr_q, drain_clr_d;
    logic               pf_v_q, pf_v_d;
    logic [ADDR_W-1:0]  pf_bin_q, pf_bin_d;
    logic               ov_q, ov_d;
    logic [ADDR_W-1:0]  ob_q, ob_d;
    logic [COUNT_W-1:0] od_q, od_d;
    logic               ol_q, ol_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, acq_q, drop_q;

    logic               s1_v_q, s2_v_q, wb_v_q;
    logic [ADDR_W-1:0]  s1_bin_q, s2_bin_q, wb_bin_q;
    logic [COUNT_W-1:0] s2_cnt_q, wb_cnt_q;

    logic               hit_ok, issue, load;
    logic               we;
    logic [ADDR_W-1:0]  waddr, raddr;
    logic [COUNT_W-1:0] wdata, rdata, opnd, inc_cnt;
    inc_op_e            op;

    assign hit_ok = hit_valid && (state_q == ST_ACQ)
                    && ({1'b0, hit_bin} < NB);

    // S1 operand: the two writes not yet visible to the RAM read win.
    always_comb begin
        opnd = rdata;
        if (s2_v_q && (s2_bin_q == s1_bin_q)) begin
            opnd = s2_cnt_q;
        end else if (wb_v_q && (wb_bin_q == s1_bin_q)) begin
            opnd = wb_cnt_q;
        end
        op = inc_op(&opnd, SATURATE != 0);
        if (op == INC_HOLD) begin
            inc_cnt = opnd;
        end else if (op == INC_WRAP) begin
            inc_cnt = '0;
        end else begin
            inc_cnt = opnd + COUNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        drain_clr_d = drain_clr_q;
        pf_v_d      = pf_v_q;
        pf_bin_d    = pf_bin_q;
        ov_d        = ov_q;
        ob_d        = ob_q;
        od_d        = od_q;
        ol_d        = ol_q;
        ovf_d       = ovf_q || (s1_v_q && (op != INC_ADD));
        issue       = 1'b0;
        load        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                unique case (cmd)
                    CMD_CLEAR: begin
                        state_d = ST_CLR;
                        ptr_d   = '0;
                        ovf_d   = 1'b0;
                    end
                    CMD_START: state_d = ST_ACQ;
                    CMD_DUMP: begin
                        state_d = ST_DUMP;
                        ptr_d   = '0;
                        pf_v_d  = 1'b0;
                    end
                    default: ;
                endcase
            end
            ST_CLR: begin
                ptr_d = ptr_q + ONE;
                if (ptr_q == NB_M1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACQ: begin
                if ((cmd == CMD_DUMP) || (cmd == CMD_CLEAR)) begin
                    state_d     = ST_DRAIN;
                    drain_clr_d = (cmd == CMD_CLEAR);
                end
            end
            ST_DRAIN: begin
                if (!s1_v_q && !s2_v_q) begin
                    ptr_d = '0;
                    if (drain_clr_q) begin
                        state_d = ST_CLR;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = ST_DUMP;
                        pf_v_d  = 1'b0;
                    end
                end
            end
            ST_DUMP: begin
                // pf_* tracks which bin the RAM read register holds.
                load  = pf_v_q && (!ov_q || out_ready);
                issue = (ptr_q < NB) && (!pf_v_q || load);
                if (issue) begin
                    pf_v_d   = 1'b1;
                    pf_bin_d = ptr_q[ADDR_W-1:0];
                    ptr_d    = ptr_q + ONE;
                end else if (load) begin
                    pf_v_d = 1'b0;
                end
                if (load) begin
                    ov_d = 1'b1;
                    ob_d = pf_bin_q;
                    od_d = rdata;
                    ol_d = (pf_bin_q == LAST);
                end else if (ov_q && out_ready) begin
                    ov_d = 1'b0;
                    ol_d = 1'b0;
                    if (ol_q) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_CLR;
        endcase
    end

    always_comb begin
        if (state_q == ST_ACQ) begin
            raddr = hit_bin;
        end else if (issue) begin
            raddr = ptr_q[ADDR_W-1:0];
        end else begin
            raddr = pf_bin_q;
        end
        we    = (state_q == ST_CLR) || s2_v_q;
        waddr = (state_q == ST_CLR) ? ptr_q[ADDR_W-1:0] : s2_bin_q;
        wdata = (state_q == ST_CLR) ? '0 : s2_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLR;
            ptr_q       <= '0;
            drain_clr_q <= 1'b0;
            pf_v_q      <= 1'b0;
            pf_bin_q    <= '0;
            ov_q        <= 1'b0;
            ob_q        <= '0;
            od_q        <= '0;
            ol_q        <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            acq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            drain_clr_q <= drain_clr_d;
            pf_v_q      <= pf_v_d;
            pf_bin_q    <= pf_bin_d;
            ov_q        <= ov_d;
            ob_q        <= ob_d;
            od_q        <= od_d;
            ol_q        <= ol_d;
            ovf_q       <= ovf_d;
            busy_q      <= (state_d == ST_CLR) || (state_d == ST_DRAIN)
                           || (state_d == ST_DUMP);
            acq_q       <= (state_d == ST_ACQ);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q   <= 1'b0;
            s1_bin_q <= '0;
            s2_v_q   <= 1'b0;
            s2_bin_q <= '0;
            s2_cnt_q <= '0;
            wb_v_q   <= 1'b0;
            wb_bin_q <= '0;
            wb_cnt_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            s1_v_q   <= hit_ok;
            s1_bin_q <= hit_bin;
            s2_v_q   <= s1_v_q;
            s2_bin_q <= s1_bin_q;
            s2_cnt_q <= inc_cnt;
            wb_v_q   <= s2_v_q;
            wb_bin_q <= s2_bin_q;
            wb_cnt_q <= s2_cnt_q;
            drop_q   <= hit_valid && !hit_ok;
        end
    end

    tcspc_hist_ram #(
        .DEPTH (NUM_BINS),
        .AW    (ADDR_W),
        .DW    (COUNT_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    assign out_valid = ov_q;
    assign out_bin   = ob_q;
    assign out_data  = od_q;
    assign out_last  = ol_q;
    assign busy      = busy_q;
    assign acq_on    = acq_q;
    assign hit_drop  = drop_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_tcspc_histogram_mem.sv
// Bench: three histogram instances (128x32 sat, 100x4 sat, 100x4 wrap)
// share stimulus and are checked against a bin-count model each cycle.
module tb_tcspc_histogram_mem;
    import tcspc_pkg::*;

    localparam int N0 = 128;
    localparam int N1 = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hv = 1'b0;
    logic [6:0] hb = '0;
    logic [1:0] cmd = CMD_NONE;
    logic rdy = 1'b1;

    logic [2:0] ov, ol, bz, aq, dr, of;
    logic [2:0][6:0] ob;
    logic [31:0] od0;
    logic [3:0] od1, od2;

    always #5 clk = ~clk;

    tcspc_histogram_mem #(.NUM_BINS(128), .ADDR_W(7), .COUNT_W(32), .SATURATE(1)) u_main (
        .clk(clk), .rst_n(rst_n), .hit_valid(hv), .hit_bin(hb), .cmd(cmd),
        .out_valid(ov[0]), .out_ready(rdy), .out_bin(ob[0]), .out_data(od0),
        .out_last(ol[0]), .busy(bz[0]), .acq_on(aq[0]), .hit_drop(dr[0]), .ovf(of[0]));

    tcspc_histogram_mem #(.NUM_BINS(100), .ADDR_W(7), .COUNT_W(4), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .hit_valid(hv), .hit_bin(hb), .cmd(cmd),
        .out_valid(ov[1]), .out_ready(rdy), .out_bin(ob[1]), .out_data(od1),
        .out_last(ol[1]), .busy(bz[1]), .acq_on(aq[1]), .hit_drop(dr[1]), .ovf(of[1]));

    tcspc_histogram_mem #(.NUM_BINS(100), .ADDR_W(7), .COUNT_W(4), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .hit_valid(hv), .hit_bin(hb), .cmd(cmd),
        .out_valid(ov[2]), .out_ready(rdy), .out_bin(ob[2]), .out_data(od2),
        .out_last(ol[2]), .busy(bz[2]), .acq_on(aq[2]), .hit_drop(dr[2]), .ovf(of[2]));

    int n_cmp = 0;
    int n_bad = 0;

    longint mdl [3][128];
    bit mof [3];
    bit macq = 0;
    bit exp_drop [3];
    int eidx [3];
    int beats [3];
    longint dmp [3][128];
    bit hold [3];
    longint hbin [3];
    longint hdat [3];

    function automatic int nbins(input int k);
        return (k == 0) ? N0 : N1;
    endfunction

    function automatic int cw(input int k);
        return (k == 0) ? 32 : 4;
    endfunction

    function automatic longint dat(input int k);
        if (k == 0) return longint'(od0);
        if (k == 1) return longint'(od1);
        return longint'(od2);
    endfunction

    function automatic void chk(input string nm, input int k, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %0d, expected %0d at %0t", nm, k, act, exp, $time);
        end
    endfunction

    function automatic void mclear();
        for (int k = 0; k < 3; k++) begin
            mof[k] = 0;
            for (int b = 0; b < 128; b++) mdl[k][b] = 0;
        end
    endfunction

    // A full bin either sticks at max (inst 0,1) or restarts at 0 (inst 2).
    function automatic void bump(input int k, input int b);
        longint mx;
        mx = (longint'(1) << cw(k)) - 1;
        if (mdl[k][b] == mx) begin
            mof[k] = 1;
            mdl[k][b] = (k == 2) ? 0 : mx;
        end else begin
            mdl[k][b] = mdl[k][b] + 1;
        end
    endfunction

    task automatic cyc(input logic v, input int b, input logic [1:0] c);
        bit nd [3];
        hv = v;
        hb = b[6:0];
        cmd = c;
        for (int k = 0; k < 3; k++) begin
            nd[k] = v && !(macq && b < nbins(k));
            if (v && macq && b < nbins(k)) bump(k, b);
        end
        if (macq && (c == CMD_DUMP || c == CMD_CLEAR)) begin
            macq = 0;
            if (c == CMD_CLEAR) mclear();
        end else if (!macq && c == CMD_START) begin
            macq = 1;
        end else if (!macq && c == CMD_CLEAR) begin
            mclear();
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) exp_drop[k] = nd[k];
        hv = 1'b0;
        cmd = CMD_NONE;
    endtask

    task automatic reset_model();
        mclear();
        macq = 0;
        for (int k = 0; k < 3; k++) begin
            eidx[k] = 0;
            hold[k] = 0;
            exp_drop[k] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                chk("hit_drop", k, dr[k], exp_drop[k]);
                if (hold[k]) begin
                    chk("hold_valid", k, ov[k], 1);
                    chk("hold_bin", k, ob[k], hbin[k]);
                    chk("hold_data", k, dat(k), hdat[k]);
                end
                if (ov[k] && rdy) begin
                    chk("beat_bin", k, ob[k], eidx[k]);
                    chk("beat_data", k, dat(k), mdl[k][eidx[k]]);
                    chk("beat_last", k, ol[k], eidx[k] == nbins(k) - 1);
                    dmp[k][ob[k]] = dat(k);
                    beats[k]++;
                    eidx[k] = (eidx[k] + 1) % nbins(k);
                end
                hold[k] = ov[k] && !rdy;
                hbin[k] = ob[k];
                hdat[k] = dat(k);
            end
        end
    end

    task automatic run_dump(input int stall_bin, input int abort_bin);
        bit stalled;
        bit done;
        stalled = 0;
        done = 0;
        for (int k = 0; k < 3; k++) beats[k] = 0;
        cyc(0, 0, CMD_DUMP);
        for (int k = 0; k < 3; k++) chk("busy_dump", k, bz[k], 1);
        for (int t = 0; t < 600 && !done; t++) begin
            if (beats[0] >= N0 && beats[1] >= N1 && beats[2] >= N1) begin
                done = 1;
            end else if (ov[0] && int'(ob[0]) == abort_bin) begin
                rst_n = 1'b0;
                #1;
                for (int k = 0; k < 3; k++) chk("abort_valid", k, ov[k], 0);
                reset_model();
                return;
            end else if (ov[0] && int'(ob[0]) == stall_bin && !stalled) begin
                rdy = 1'b0;
                repeat (3) cyc(0, 0, CMD_NONE);
                chk("stall_bin", 0, ob[0], stall_bin);
                rdy = 1'b1;
                stalled = 1;
            end else begin
                cyc(0, 0, CMD_NONE);
            end
        end
        for (int k = 0; k < 3; k++) chk("beats", k, beats[k], nbins(k));
        cyc(0, 0, CMD_NONE);
        for (int k = 0; k < 3; k++) begin
            chk("busy_idle", k, bz[k], 0);
            chk("valid_idle", k, ov[k], 0);
        end
    endtask

    initial begin
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", k, ov[k], 0);
            chk("rst_busy", k, bz[k], 0);
            chk("rst_acq", k, aq[k], 0);
            chk("rst_ovf", k, of[k], 0);
            chk("rst_bin", k, ob[k], 0);
            chk("rst_data", k, dat(k), 0);
        end
        rst_n = 1'b1;
        repeat (N0 + 1) cyc(0, 0, CMD_NONE);
        for (int k = 0; k < 3; k++) chk("swept_busy", k, bz[k], 0);
        run_dump(-1, -1);

        cyc(0, 0, CMD_START);
        for (int k = 0; k < 3; k++) chk("acq_on", k, aq[k], 1);
        cyc(1, 5, CMD_NONE);
        cyc(1, 5, CMD_NONE);
        cyc(1, 5, CMD_NONE);
        cyc(1, 9, CMD_NONE);
        run_dump(-1, -1);
        chk("lit_bin5", 0, dmp[0][5], 3);
        chk("lit_bin9", 0, dmp[0][9], 1);
        chk("lit_bin4", 0, dmp[0][4], 0);

        cyc(0, 0, CMD_START);
        repeat (20) cyc(1, 3, CMD_NONE);
        cyc(1, 7, CMD_NONE);
        cyc(1, 8, CMD_NONE);
        cyc(1, 7, CMD_NONE);
        cyc(1, 8, CMD_NONE);
        cyc(1, 7, CMD_NONE);
        run_dump(-1, -1);
        chk("lit_sat_bin3", 1, dmp[1][3], 15);
        chk("lit_wrap_bin3", 2, dmp[2][3], 4);
        chk("lit_main_bin3", 0, dmp[0][3], 20);
        chk("lit_main_bin7", 0, dmp[0][7], 3);
        chk("lit_main_bin8", 0, dmp[0][8], 2);
        chk("lit_ovf", 0, of[0], 0);
        chk("lit_ovf", 1, of[1], 1);
        chk("lit_ovf", 2, of[2], 1);

        cyc(1, 7, CMD_NONE);
        for (int k = 0; k < 3; k++) chk("lit_idle_drop", k, dr[k], 1);
        cyc(1, 7, CMD_NONE);
        cyc(0, 0, CMD_START);
        cyc(1, 127, CMD_NONE);
        chk("lit_range_drop", 0, dr[0], 0);
        chk("lit_range_drop", 1, dr[1], 1);
        cyc(1, 99, CMD_NONE);
        run_dump(10, -1);
        chk("lit_bin127", 0, dmp[0][127], 1);
        chk("lit_bin99", 1, dmp[1][99], 1);
        chk("lit_bin7_kept", 0, dmp[0][7], 3);
        for (int k = 0; k < 3; k++) chk("ovf", k, of[k], mof[k]);

        cyc(0, 0, CMD_START);
        cyc(1, 2, CMD_NONE);
        cyc(1, 2, CMD_CLEAR);
        repeat (140) cyc(0, 0, CMD_NONE);
        for (int k = 0; k < 3; k++) begin
            chk("clr_busy", k, bz[k], 0);
            chk("clr_ovf", k, of[k], 0);
        end
        run_dump(-1, -1);
        chk("lit_cleared", 0, dmp[0][3], 0);

        run_dump(-1, 40);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (N0 + 1) cyc(0, 0, CMD_NONE);
        run_dump(-1, -1);
        for (int k = 0; k < 3; k++) chk("post_rst_ovf", k, of[k], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
